// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Purpose:
//   Instruction fetch front end.  Issues one word-aligned request at a time
//   to instruction memory, buffers the returned word together with its PC,
//   and presents it to the fetch-to-EX register.  Handles taken-branch
//   redirects from EX (including dropping a response that belongs to the
//   old path) and back-pressure from the hazard unit.
//
// Handshake rules (memory side):
//   A request transfers on a rising edge where imem_req_valid and
//   imem_req_ready are both high.  Once imem_req_valid is raised it is
//   held, with imem_req_addr stable, until accepted, unless a redirect
//   arrives.  Each accepted request returns exactly one imem_rsp_valid
//   pulse, in order; at most one request is outstanding at any time.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   redirect_valid/pc   branch/jump taken in EX and its target
//   stall_in            EX cannot accept a new instruction this cycle
//   imem_req_*          request channel to instruction memory
//   imem_rsp_*          response channel from instruction memory
//   inst_fetch          instruction to the fetch-to-EX register
//   pc_out_fetch        PC of inst_fetch
//   flush_id_ex         load a NOP into the fetch-to-EX register
//   stall_id_ex         hold the fetch-to-EX register
//   o_dbg_state         current FSM state (0 = S_REQ, 1 = S_WAIT)
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall_in,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] inst_fetch,
    output logic [31:0] pc_out_fetch,
    output logic        flush_id_ex,
    output logic        stall_id_ex,
    output logic        o_dbg_state
);

    localparam logic [31:0] NOP = 32'h0000_0033;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_inflight_pc;
    logic [31:0] r_inst_buf;
    logic [31:0] r_pc_buf;
    logic        r_buf_valid;
    logic        r_discard;

    logic        w_consume;
    logic        w_req_valid;
    logic        w_req_fire;
    logic [31:0] w_redirect_aligned;

    // The buffered word leaves this cycle when EX takes it and no redirect
    // kills it.
    assign w_consume          = r_buf_valid & ~stall_in & ~redirect_valid;
    assign w_redirect_aligned = {redirect_pc[31:2], 2'b00};

    // A new request is only issued when the buffer will have room for the
    // response: it is empty now or is being emptied this cycle.
    assign w_req_valid = (r_state == S_REQ) & ~redirect_valid &
                         (~r_buf_valid | w_consume);
    assign w_req_fire  = w_req_valid & imem_req_ready;

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_REQ: begin
                if (w_req_fire) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // A redirect without a response keeps waiting for the stale
                // response so it can be dropped.
                if (imem_rsp_valid) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    // ---------------- state and datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_REQ;
            r_pc          <= RESET_PC;
            r_inflight_pc <= 32'h0;
            r_inst_buf    <= 32'h0;
            r_pc_buf      <= 32'h0;
            r_buf_valid   <= 1'b0;
            r_discard     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (redirect_valid) begin
                r_pc        <= w_redirect_aligned;
                r_buf_valid <= 1'b0;
                if (r_state == S_WAIT) begin
                    // Same-cycle response is the stale one: drop it now.
                    // Otherwise remember to drop it when it arrives.
                    r_discard <= ~imem_rsp_valid;
                end
            end else begin
                if (w_consume) begin
                    r_buf_valid <= 1'b0;
                end

                if (w_req_fire) begin
                    r_inflight_pc <= r_pc;
                    r_pc          <= r_pc + 32'd4;
                end

                if ((r_state == S_WAIT) && imem_rsp_valid) begin
                    if (r_discard) begin
                        r_discard <= 1'b0;
                    end else begin
                        // Capture wins over a same-cycle consume.
                        r_inst_buf  <= imem_rsp_data;
                        r_pc_buf    <= r_inflight_pc;
                        r_buf_valid <= 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- outputs ----------------
    // While rst is high the registers may still hold pre-reset contents,
    // so the outputs are forced to their idle values.
    always_comb begin
        imem_req_valid = 1'b0;
        imem_req_addr  = r_pc;
        inst_fetch     = NOP;
        pc_out_fetch   = 32'h0;
        flush_id_ex    = 1'b1;
        stall_id_ex    = 1'b0;
        if (!rst) begin
            imem_req_valid = w_req_valid;
            if (r_buf_valid) begin
                inst_fetch   = r_inst_buf;
                pc_out_fetch = r_pc_buf;
            end
            if (redirect_valid) begin
                flush_id_ex = 1'b1;
                stall_id_ex = 1'b0;
            end else if (stall_in) begin
                flush_id_ex = 1'b0;
                stall_id_ex = 1'b1;
            end else if (r_buf_valid) begin
                flush_id_ex = 1'b0;
                stall_id_ex = 1'b0;
            end else begin
                flush_id_ex = 1'b1;
                stall_id_ex = 1'b0;
            end
        end
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Purpose:
//   Self-checking bench for pc_fetch_unit.  A table of per-cycle input
//   vectors with hand-computed expected outputs walks through reset, normal
//   fetch, stalls, ready back-pressure, redirects and PC wrap.  A second
//   hand-written sequence runs a reactive 1-cycle memory and checks the
//   delivered instruction stream against an expected queue.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0033;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall_in;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] inst_fetch;
    logic [31:0] pc_out_fetch;
    logic        flush_id_ex;
    logic        stall_id_ex;
    logic        dbg_state;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_in       (stall_in),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_fetch     (inst_fetch),
        .pc_out_fetch   (pc_out_fetch),
        .flush_id_ex    (flush_id_ex),
        .stall_id_ex    (stall_id_ex),
        .o_dbg_state    (dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        st;
        logic        rdy;
        logic        rspv;
        logic [31:0] rspd;
        logic        e_rv;
        logic [31:0] e_ra;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic        e_fl;
        logic        e_st;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic rv, input logic [31:0] rpc,
                       input logic st, input logic rdy, input logic rspv,
                       input logic [31:0] rspd, input logic e_rv,
                       input logic [31:0] e_ra, input logic [31:0] e_inst,
                       input logic [31:0] e_pc, input logic e_fl,
                       input logic e_st);
        vec_t v;
        v.rst = r;   v.rv = rv;   v.rpc = rpc;   v.st = st;  v.rdy = rdy;
        v.rspv = rspv; v.rspd = rspd; v.e_rv = e_rv; v.e_ra = e_ra;
        v.e_inst = e_inst; v.e_pc = e_pc; v.e_fl = e_fl; v.e_st = e_st;
        vecs.push_back(v);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input vec_t v);
        rst            = v.rst;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        stall_in       = v.st;
        imem_req_ready = v.rdy;
        imem_rsp_valid = v.rspv;
        imem_rsp_data  = v.rspd;
    endtask

    // expected queue for the streaming sequence: {instruction, pc}
    logic [63:0] exp_q[$];

    initial begin
        vec_t idle;
        logic        pend;
        logic        pend_nxt;
        logic [31:0] pend_addr;
        logic [31:0] pend_addr_nxt;
        logic [63:0] e;
        int          consumed;

        idle = '{rst:1'b1, rv:1'b0, rpc:32'h0, st:1'b0, rdy:1'b0, rspv:1'b0,
                 rspd:32'h0, e_rv:1'b0, e_ra:32'h0, e_inst:NOP, e_pc:32'h0,
                 e_fl:1'b1, e_st:1'b0};
        drive(idle);

        //   rst rv rpc           st rdy rspv rspd          e_rv e_ra          e_inst        e_pc          fl st
        // reset
        add(1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        NOP,          32'h0,        1, 0);
        add(1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        NOP,          32'h0,        1, 0);
        // response in the first cycle after reset is ignored
        add(0, 0, 32'h0,        0, 0, 1, 32'hDEAD_BEEF, 1, 32'h0,       NOP,          32'h0,        1, 0);
        // normal 1-cycle memory: 0, 4, 8
        add(0, 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h0,        NOP,          32'h0,        1, 0);
        add(0, 0, 32'h0,        0, 1, 1, 32'hA5A5_0000, 0, 32'h0,       NOP,          32'h0,        1, 0);
        add(0, 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h4,        32'hA5A5_0000, 32'h0,       0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 32'hA5A5_0004, 0, 32'h0,       NOP,          32'h0,        1, 0);
        add(0, 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h8,        32'hA5A5_0004, 32'h4,       0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 32'hA5A5_0008, 0, 32'h0,       NOP,          32'h0,        1, 0);
        // stall with a buffered instruction, 3 cycles, then release
        add(0, 0, 32'h0,        1, 1, 0, 32'h0,        0, 32'h0,        32'hA5A5_0008, 32'h8,       0, 1);
        add(0, 0, 32'h0,        1, 1, 0, 32'h0,        0, 32'h0,        32'hA5A5_0008, 32'h8,       0, 1);
        add(0, 0, 32'h0,        1, 1, 0, 32'h0,        0, 32'h0,        32'hA5A5_0008, 32'h8,       0, 1);
        add(0, 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'hC,        32'hA5A5_0008, 32'h8,       0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 32'hA5A5_000C, 0, 32'h0,       NOP,          32'h0,        1, 0);
        add(0, 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h10,       32'hA5A5_000C, 32'hC,       0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 32'hA5A5_0010, 0, 32'h0,       NOP,          32'h0,        1, 0);
        // ready low: buffer drains, request held stable at 0x14
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h14,       32'hA5A5_0010, 32'h10,      0, 0);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h14,       NOP,          32'h0,        1, 0);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h14,       NOP,          32'h0,        1, 0);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h14,       NOP,          32'h0,        1, 0);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h14,       NOP,          32'h0,        1, 0);
        add(0, 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h14,       NOP,          32'h0,        1, 0);
        // redirect to 0x103 while waiting; stale response dropped
        add(0, 1, 32'h0000_0103, 0, 1, 0, 32'h0,       0, 32'h0,        NOP,          32'h0,        1, 0);
        add(0, 0, 32'h0,        0, 1, 1, 32'hA5A5_0014, 0, 32'h0,       NOP,          32'h0,        1, 0);
        add(0, 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h100,      NOP,          32'h0,        1, 0);
        add(0, 0, 32'h0,        0, 1, 1, 32'hA5A5_0100, 0, 32'h0,       NOP,          32'h0,        1, 0);
        add(0, 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h104,      32'hA5A5_0100, 32'h100,     0, 0);
        // redirect and response in the same cycle
        add(0, 1, 32'h0000_0200, 0, 1, 1, 32'hA5A5_0104, 0, 32'h0,      NOP,          32'h0,        1, 0);
        add(0, 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h200,      NOP,          32'h0,        1, 0);
        add(0, 0, 32'h0,        0, 1, 1, 32'hA5A5_0200, 0, 32'h0,       NOP,          32'h0,        1, 0);
        // redirect beats stall; low bits ignored; then wrap FFFF_FFFC -> 0
        add(0, 1, 32'hFFFF_FFFE, 1, 1, 0, 32'h0,       0, 32'h0,        32'hA5A5_0200, 32'h200,     1, 0);
        add(0, 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'hFFFF_FFFC, NOP,         32'h0,        1, 0);
        add(0, 0, 32'h0,        0, 1, 1, 32'h5A5A_FFFC, 0, 32'h0,       NOP,          32'h0,        1, 0);
        add(0, 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h0,        32'h5A5A_FFFC, 32'hFFFF_FFFC, 0, 0);
        // stall without a buffered word: fetch continues, word held
        add(0, 0, 32'h0,        1, 1, 1, 32'hA5A5_0000, 0, 32'h0,       NOP,          32'h0,        0, 1);
        add(0, 0, 32'h0,        1, 1, 0, 32'h0,        0, 32'h0,        32'hA5A5_0000, 32'h0,       0, 1);
        add(0, 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h4,        32'hA5A5_0000, 32'h0,       0, 0);
        // reset mid-request; late response afterwards is ignored
        add(1, 0, 32'h0,        0, 1, 0, 32'h0,        0, 32'h0,        NOP,          32'h0,        1, 0);
        add(0, 0, 32'h0,        0, 0, 1, 32'h1234_5678, 1, 32'h0,       NOP,          32'h0,        1, 0);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        NOP,          32'h0,        1, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check("req_valid", i, {31'h0, imem_req_valid}, {31'h0, vecs[i].e_rv});
            if (vecs[i].e_rv) begin
                check("req_addr", i, imem_req_addr, vecs[i].e_ra);
            end
            check("inst_fetch", i, inst_fetch, vecs[i].e_inst);
            check("pc_out", i, pc_out_fetch, vecs[i].e_pc);
            check("flush", i, {31'h0, flush_id_ex}, {31'h0, vecs[i].e_fl});
            check("stall", i, {31'h0, stall_id_ex}, {31'h0, vecs[i].e_st});
        end

        // ---------------- streaming sequence with reactive memory ----------------
        @(negedge clk);
        drive(idle);
        @(negedge clk);
        pend      = 1'b0;
        pend_addr = 32'h0;
        consumed  = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            rst            = 1'b0;
            redirect_valid = 1'b0;
            stall_in       = 1'b0;
            imem_req_ready = 1'b1;
            imem_rsp_valid = pend;
            imem_rsp_data  = pend_addr ^ KEY;
            #1;
            if (!flush_id_ex && !stall_id_ex) begin
                if (exp_q.size() == 0) begin
                    check("stream_unexpected", c, pc_out_fetch, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_inst", c, inst_fetch, e[63:32]);
                    check("stream_pc", c, pc_out_fetch, e[31:0]);
                    consumed++;
                end
            end
            pend_nxt      = 1'b0;
            pend_addr_nxt = 32'h0;
            if (imem_req_valid && imem_req_ready) begin
                exp_q.push_back({imem_req_addr ^ KEY, imem_req_addr});
                pend_nxt      = 1'b1;
                pend_addr_nxt = imem_req_addr;
            end
            @(posedge clk);
            pend      = pend_nxt;
            pend_addr = pend_addr_nxt;
        end
        // one instruction every two cycles, first delivered in cycle 2
        check("stream_count", 0, consumed, 32'd19);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // hard time limit so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1);
    end

endmodule
